// File: rtl/imm_ext_unit.sv
// Immediate-extension stage: decodes the RISC-V immediate selected by in_fmt into an
// XLEN-bit operand and holds it in a 2-entry skid buffer with valid/ready on both sides.
module imm_ext_unit #(
    parameter int XLEN          = 32,
    parameter int TAG_W         = 5,
    parameter bit LEGACY_S_ZEXT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_S     = 3'd1,
        FMT_B     = 3'd2,
        FMT_U     = 3'd3,
        FMT_J     = 3'd4,
        FMT_SHAMT = 3'd5,
        FMT_ZIMM  = 3'd6,
        FMT_RSVD  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    logic [11:0]     s_field;
    entry_t          new_entry;
    entry_t          or_q;
    entry_t          sr_q;
    logic            or_valid;
    logic            sr_valid;
    logic            accept;
    logic            pop;

    // The opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    assign s_field = {in_instr[31:25], in_instr[11:7]};

    // NOTE: every output of a combinational block gets a default first so that no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        unique case (fmt_e'(in_fmt))
            FMT_I:     ext_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            FMT_S:     ext_imm = LEGACY_S_ZEXT ? {{(XLEN-12){1'b0}}, s_field}
                                               : {{(XLEN-12){s_field[11]}}, s_field};
            FMT_B:     ext_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:     ext_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            FMT_J:     ext_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
            FMT_SHAMT: ext_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, in_instr[25:20]}
                                              : {{(XLEN-5){1'b0}}, in_instr[24:20]};
            FMT_ZIMM:  ext_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            FMT_RSVD:  ext_err = 1'b1;
        endcase
    end

    assign new_entry = '{imm: ext_imm, tag: in_tag, err: ext_err};

    // Holding reset low also blocks new input, so nothing slips in while entries are discarded.
    assign in_ready = !sr_valid && rst_n;
    assign accept   = in_valid && in_ready;
    assign pop      = or_valid && out_ready;

    // NOTE: the payload registers are reset too, because the outputs must read zero
    // after reset rather than whatever was last held.
    // NOTE: sequential state uses non-blocking assignments only, so every branch reads
    // the pre-edge values of or_q/sr_q and the SR->OR move cannot race the capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            or_q     <= '0;
            sr_q     <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
        end else if (pop && sr_valid) begin
            or_q     <= sr_q;
            sr_valid <= 1'b0;
        end else if (accept && (!or_valid || pop)) begin
            or_q     <= new_entry;
            or_valid <= 1'b1;
        end else if (accept) begin
            sr_q     <= new_entry;
            sr_valid <= 1'b1;
        end else if (pop) begin
            or_valid <= 1'b0;
        end
    end

    assign out_valid = or_valid;
    assign out_imm   = or_q.imm;
    assign out_tag   = or_q.tag;
    assign out_err   = or_q.err;

    // The skid entry is only ever filled behind a held output entry.
    a_sr_implies_or: assert property (@(posedge clk) disable iff (!rst_n) sr_valid |-> or_valid);

    a_stable_when_stalled: assert property (@(posedge clk) disable iff (!rst_n || flush)
        (or_valid && !out_ready) |=> (or_valid && $stable(or_q)));

endmodule

// File: tb/tb_imm_ext_unit.sv
// Bench for imm_ext_unit: three instances (XLEN=32, XLEN=32 legacy S, XLEN=64) share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_imm_ext_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [2:0]       in_fmt = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             a_in_ready, a_out_valid, a_out_err;
    logic [31:0]      a_out_imm;
    logic [TAG_W-1:0] a_out_tag;
    logic             b_in_ready, b_out_valid, b_out_err;
    logic [31:0]      b_out_imm;
    logic [TAG_W-1:0] b_out_tag;
    logic             c_in_ready, c_out_valid, c_out_err;
    logic [63:0]      c_out_imm;
    logic [TAG_W-1:0] c_out_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_ext_unit #(.XLEN(32), .TAG_W(TAG_W), .LEGACY_S_ZEXT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_imm(a_out_imm), .out_tag(a_out_tag), .out_err(a_out_err));

    imm_ext_unit #(.XLEN(32), .TAG_W(TAG_W), .LEGACY_S_ZEXT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_imm(b_out_imm), .out_tag(b_out_tag), .out_err(b_out_err));

    imm_ext_unit #(.XLEN(64), .TAG_W(TAG_W), .LEGACY_S_ZEXT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_imm(c_out_imm), .out_tag(c_out_tag), .out_err(c_out_err));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sign-extend an n-bit field held in the low bits of f.
    function automatic longint sx(input longint f, input int n);
        return (f >= (64'sd1 <<< (n - 1))) ? f - (64'sd1 <<< n) : f;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt,
                                            input int xlen, input bit legacy);
        longint v;
        longint s;
        s = longint'({ins[31:25], ins[11:7]});
        case (fmt)
            3'd0:    v = sx(longint'(ins[31:20]), 12);
            3'd1:    v = legacy ? s : sx(s, 12);
            3'd2:    v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            3'd3:    v = sx(longint'({ins[31:12], 12'h000}), 32);
            3'd4:    v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            3'd5:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6:    v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
    endfunction

    // Reference model: an ordered list of accepted-but-not-popped requests, capacity two.
    typedef struct {
        logic [31:0]      instr;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } txn_t;

    txn_t q[$];
    bit   zero_state = 1'b1;
    bit   started = 1'b0;
    bit   can_push;
    bit   do_pop;
    logic [TAG_W-1:0] dut_popped[$];

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            q.delete();
            zero_state = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            can_push = (q.size() < 2);
            do_pop   = (q.size() > 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (in_valid && can_push) begin
                q.push_back('{instr: in_instr, fmt: in_fmt, tag: in_tag});
                zero_state = 1'b0;
            end
        end
    end

    // Single compare process, on the falling edge where all DUT outputs are settled.
    always @(negedge clk) begin
        if (started) begin
            check("in_ready_a", 64'(a_in_ready), 64'(rst_n && q.size() < 2));
            check("in_ready_b", 64'(b_in_ready), 64'(rst_n && q.size() < 2));
            check("in_ready_c", 64'(c_in_ready), 64'(rst_n && q.size() < 2));
            check("out_valid_a", 64'(a_out_valid), 64'(q.size() > 0));
            check("out_valid_b", 64'(b_out_valid), 64'(q.size() > 0));
            check("out_valid_c", 64'(c_out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("imm_a", 64'(a_out_imm), ref_imm(q[0].instr, q[0].fmt, 32, 1'b0));
                check("imm_b", 64'(b_out_imm), ref_imm(q[0].instr, q[0].fmt, 32, 1'b1));
                check("imm_c", c_out_imm, ref_imm(q[0].instr, q[0].fmt, 64, 1'b0));
                check("tag_a", 64'(a_out_tag), 64'(q[0].tag));
                check("tag_c", 64'(c_out_tag), 64'(q[0].tag));
                check("err_a", 64'(a_out_err), 64'(q[0].fmt == 3'd7));
                check("err_c", 64'(c_out_err), 64'(q[0].fmt == 3'd7));
            end else if (zero_state) begin
                check("rst_imm_a", 64'(a_out_imm), 64'd0);
                check("rst_imm_c", c_out_imm, 64'd0);
                check("rst_tag_a", 64'(a_out_tag), 64'd0);
                check("rst_err_a", 64'(a_out_err), 64'd0);
            end
            if (a_out_valid && out_ready) dut_popped.push_back(a_out_tag);
        end
    end

    // Inputs change only at posedge+1 or negedge+1, away from the model and compare edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // One request with out_ready=1; returns in the cycle its result must be on out_*.
    task automatic send(input logic [31:0] ins, input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_fmt    = fmt;
        in_tag    = tag;
        step();
        in_valid = 1'b0;
        sample();
        check("latency_valid", 64'(a_out_valid), 64'd1);
    endtask

    initial begin
        int t;
        int cyc;
        bit acc;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Hand-computed pins of the extension rules.
        send(32'hFE112E23, 3'd1, 5'd1);
        check("sw_s_sext32", 64'(a_out_imm), 64'h0000_0000_FFFF_FFFC);
        check("sw_s_zext32", 64'(b_out_imm), 64'h0000_0000_0000_0FFC);
        check("sw_s_sext64", c_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        send(32'h40735293, 3'd5, 5'd2);
        check("srai_shamt32", 64'(a_out_imm), 64'h7);
        check("srai_shamt64", c_out_imm, 64'h7);
        send(32'hFE000CE3, 3'd2, 5'd3);
        check("beq_b32", 64'(a_out_imm), 64'h0000_0000_FFFF_FFF8);
        send(32'h123450B7, 3'd3, 5'd4);
        check("lui_u32", 64'(a_out_imm), 64'h0000_0000_1234_5000);
        check("lui_u64", c_out_imm, 64'h0000_0000_1234_5000);
        send(32'h823450B7, 3'd3, 5'd5);
        check("lui_u64_neg", c_out_imm, 64'hFFFF_FFFF_8234_5000);
        send(32'hDEADBEEF, 3'd7, 5'd6);
        check("rsvd_imm", 64'(a_out_imm), 64'd0);
        check("rsvd_err", 64'(a_out_err), 64'd1);
        send(32'hFFF00093, 3'd0, 5'd7);
        check("addi_i32", 64'(a_out_imm), 64'h0000_0000_FFFF_FFFF);
        check("after_rsvd_err", 64'(a_out_err), 64'd0);
        step();

        // Back-pressure: tags 1..6 streamed, consumer stalled for the first 4 cycles.
        dut_popped.delete();
        t = 1;
        cyc = 0;
        while (t <= 6 && cyc < 100) begin
            in_valid  = 1'b1;
            in_tag    = TAG_W'(t);
            in_fmt    = 3'(t % 7);
            in_instr  = $urandom;
            out_ready = (cyc >= 4);
            sample();
            acc = a_in_ready;
            if (cyc == 2) begin
                check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
                check("bp_head_tag", 64'(a_out_tag), 64'd1);
            end
            if (cyc == 3) check("bp_head_stable", 64'(a_out_tag), 64'd1);
            step();
            if (acc) t++;
            cyc++;
        end
        check("bp_all_accepted", 64'(t), 64'd7);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("bp_pop_count", 64'(dut_popped.size()), 64'd6);
        for (int i = 0; i < dut_popped.size() && i < 6; i++)
            check("bp_pop_order", 64'(dut_popped[i]), 64'(i + 1));

        // Flush with both entries held and an input offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_instr  = 32'h00100093;
        in_tag    = 5'd10;
        step();
        in_tag = 5'd11;
        step();
        flush  = 1'b1;
        in_tag = 5'd31;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sample();
        check("flush_out_valid", 64'(a_out_valid), 64'd0);
        check("flush_in_ready", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            sample();
            check("flush_no_ghost", 64'(a_out_valid), 64'd0);
        end

        // Reset for one edge with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd12;
        step();
        in_tag = 5'd13;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_imm", 64'(a_out_imm), 64'd0);
        check("rst_out_tag", 64'(a_out_tag), 64'd0);
        check("rst_in_ready_after", 64'(a_in_ready), 64'd1);
        send(32'h00500093, 3'd0, 5'd14);
        check("post_rst_imm", 64'(a_out_imm), 64'h5);
        check("post_rst_tag", 64'(a_out_tag), 64'd14);

        // Randomized traffic with occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_fmt    = 3'($urandom_range(0, 7));
            in_instr  = $urandom;
            in_tag    = TAG_W'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
